// File: rtl/fetch_buffer.sv
// fetch_buffer: issues one imem read per cycle on a credit basis and
// queues {pc, instr} pairs for decode; flush drops everything in flight.
module fetch_buffer #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PC_W-1:0]          pc,
  output logic                     en_pc,
  input  logic                     flush,
  output logic [PC_W-1:0]          imem_addr,
  output logic                     imem_en,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [PC_W-1:0]          dec_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    START,
    RUN,
    FULL
  } state_t;

  state_t state, state_n;

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_buf  [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [PC_W-1:0]    pc_q;
  logic               inflight;

  logic               pop, push, issue;
  logic [CW:0]        credit;
  logic [CW-1:0]      cnt_n;

  assign pop    = dec_valid && dec_ready;
  assign push   = inflight && !flush;
  assign credit = {1'b0, count}
                + {{CW{1'b0}}, inflight}
                - {{CW{1'b0}}, pop};
  assign issue  = (state != START) && !flush
                && (credit < FULL_C);

  assign en_pc     = issue;
  assign imem_en   = issue;
  assign imem_addr = pc;

  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? instr_q[rd_ptr] : '0;
  assign dec_pc    = dec_valid ? pc_buf[rd_ptr]  : '0;

  // Occupancy after this cycle's push/pop; flush empties the queue.
  always_comb begin
    cnt_n = count;
    if (flush)
      cnt_n = '0;
    else
      cnt_n = count
            + {{(CW-1){1'b0}}, push}
            - {{(CW-1){1'b0}}, pop};
  end

  // Next state: FULL whenever the committed credit fills the buffer.
  always_comb begin
    state_n = state;
    unique case (state)
      START: state_n = flush ? START : RUN;
      RUN, FULL: begin
        if ({1'b0, cnt_n} + {{CW{1'b0}}, issue} >= FULL_C)
          state_n = FULL;
        else
          state_n = RUN;
      end
      default: state_n = START;
    endcase
  end

  // State, pointers, occupancy and the single outstanding request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= START;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      pc_q     <= '0;
    end else begin
      state    <= state_n;
      count    <= cnt_n;
      inflight <= issue;
      if (issue)
        pc_q <= pc;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Entry storage, written by the memory response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_buf[i]  <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_buf[wr_ptr]  <= pc_q;
    end
  end

  no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(push && ({1'b0, count} == FULL_C)));

endmodule
